fifo_port_ctrl: RTL and testbench

Controller that sits around the 16-deep, 8-bit synchronous FIFO and sequences both of its ports. Two producers share the FIFO write port under round-robin arbitration. The read side turns the FIFO's one-cycle registered read into a valid/ready stream for a single consumer, at full throughput. The block also provides a flush sequence and occupancy and traffic counters for firmware visibility.

---
 rtl/fifo_port_ctrl.sv | 129 ++++++++++++
 tb/tb_fifo_port_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_port_ctrl.sv
// Port sequencer for a 16-deep registered-read FIFO: round-robin write arbitration
// between two producers, valid/ready read stream, flush sequence and occupancy counters.
module fifo_port_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req0_valid,
    input  logic [DATA_W-1:0]       req0_data,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [DATA_W-1:0]       req1_data,
    output logic                    req1_ready,
    output logic                    fifo_write,
    output logic [DATA_W-1:0]       fifo_wdata,
    input  logic                    fifo_full,
    output logic                    fifo_read,
    input  logic [DATA_W-1:0]       fifo_rdata,
    input  logic                    fifo_empty,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    flush_busy,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        acc0_cnt,
    output logic [CNT_W-1:0]        acc1_cnt
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

    state_t             r_state;
    logic               r_prio;
    logic               r_vld_p1;
    logic               r_flush_busy;
    logic [LVL_W-1:0]   r_level;
    logic [CNT_W-1:0]   r_acc0;
    logic [CNT_W-1:0]   r_acc1;

    logic               w_run;
    logic               w_en;
    logic               w_sel1;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_pop;
    logic [1:0]         w_dec;

    assign w_run  = (r_state == S_RUN);
    assign w_en   = w_run & ~fifo_full;
    // req1 wins when it is the only requester or when both request and prio favours it
    assign w_sel1 = req1_valid & (~req0_valid | r_prio);

    assign req0_ready = w_en & ~w_sel1;
    assign req1_ready = w_en & ~(req0_valid & (~req1_valid | ~r_prio));
    assign w_acc0     = req0_valid & req0_ready;
    assign w_acc1     = req1_valid & req1_ready;
    assign fifo_write = w_acc0 | w_acc1;
    assign fifo_wdata = w_sel1 ? req1_data : req0_data;

    assign fifo_read  = ~fifo_empty & (~w_run | ~r_vld_p1 | out_ready);
    assign w_pop      = r_vld_p1 & out_ready;

    // On the flush-entry edge both the held word and any word read that cycle are discarded
    always_comb begin
        w_dec = 2'd0;
        if (!w_run)
            w_dec = {1'b0, fifo_read};
        else if (flush)
            w_dec = {1'b0, r_vld_p1} + {1'b0, fifo_read};
        else
            w_dec = {1'b0, w_pop};
    end

    // ---- stage p1: registered output valid, FSM and counters ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_RUN;
            r_prio       <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_flush_busy <= 1'b0;
            r_level      <= '0;
            r_acc0       <= '0;
            r_acc1       <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (flush) begin
                        r_state      <= S_FLUSH;
                        r_flush_busy <= 1'b1;
                        r_vld_p1     <= 1'b0;
                    end else begin
                        r_vld_p1 <= fifo_read | (r_vld_p1 & ~out_ready);
                    end
                end
                S_FLUSH: begin
                    r_vld_p1 <= 1'b0;
                    if (fifo_empty & ~fifo_read) begin
                        r_state      <= S_RUN;
                        r_flush_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_RUN;
                    r_flush_busy <= 1'b0;
                    r_vld_p1     <= 1'b0;
                end
            endcase
            if (fifo_write)
                r_prio <= w_acc0;
            if (w_acc0)
                r_acc0 <= r_acc0 + CNT_W'(1);
            if (w_acc1)
                r_acc1 <= r_acc1 + CNT_W'(1);
            r_level <= r_level + LVL_W'(fifo_write) - LVL_W'(w_dec);
        end
    end

    assign out_valid  = r_vld_p1;
    assign out_data   = fifo_rdata;
    assign flush_busy = r_flush_busy;
    assign level      = r_level;
    assign acc0_cnt   = r_acc0;
    assign acc1_cnt   = r_acc1;

endmodule

// File: tb/tb_fifo_port_ctrl.sv
// Bench for fifo_port_ctrl with a behavioural 16x8 registered-read FIFO and an output scoreboard.
module tb_fifo_port_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   req0_valid, req1_valid;
    logic [DATA_W-1:0]      req0_data, req1_data;
    logic                   req0_ready, req1_ready;
    logic                   fifo_write, fifo_read;
    logic [DATA_W-1:0]      fifo_wdata;
    logic [DATA_W-1:0]      fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic                   out_valid, out_ready;
    logic [DATA_W-1:0]      out_data;
    logic                   flush, flush_busy;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       acc0_cnt, acc1_cnt;

    fifo_port_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(clk), .RST(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .fifo_write(fifo_write), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .fifo_read(fifo_read), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .flush(flush), .flush_busy(flush_busy), .level(level),
        .acc0_cnt(acc0_cnt), .acc1_cnt(acc1_cnt)
    );

    // Behavioural FIFO: registered read, reset by RSTn = ~RST on the same edge
    logic [DATA_W-1:0] mem [DEPTH];
    logic [3:0]        wp, rp;
    logic [4:0]        cnt;
    logic              fifo_rstn;
    assign fifo_rstn  = ~rst;
    assign fifo_full  = (cnt == 5'd16);
    assign fifo_empty = (cnt == 5'd0);

    always @(posedge clk) begin
        if (!fifo_rstn) begin
            wp <= '0; rp <= '0; cnt <= '0; fifo_rdata <= '0;
        end else begin
            if (fifo_write && !fifo_full) begin
                mem[wp] <= fifo_wdata;
                wp      <= wp + 4'd1;
            end
            if (fifo_read && !fifo_empty) begin
                fifo_rdata <= mem[rp];
                rp         <= rp + 4'd1;
            end
            cnt <= cnt + 5'(fifo_write && !fifo_full) - 5'(fifo_read && !fifo_empty);
        end
    end

    int errors = 0;
    int checks = 0;
    int n0, n1;
    logic [DATA_W-1:0] q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample before the rising edge, score handshakes, return at the next falling edge
    task automatic step();
        logic a0, a1;
        logic [DATA_W-1:0] e;
        #1;
        chk("write_while_full", 32'(fifo_write && fifo_full), 32'd0);
        chk("read_while_empty", 32'(fifo_read && fifo_empty), 32'd0);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        if (out_valid && out_ready) begin
            chk("sb_has_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_word", 32'(out_data), 32'(e));
            end
        end
        @(negedge clk);
        if (a0) begin n0++; req0_data = req0_data + 8'd1; end
        if (a1) begin n1++; req1_data = req1_data + 8'd1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        n0 = 0; n1 = 0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        chk("drain_complete", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int g;
        int nb;
        logic prev_stall;
        logic [DATA_W-1:0] prev_data;
        req0_data = '0; req1_data = '0;

        // Reset then idle
        do_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd1);
        chk("rst_req1_ready", 32'(req1_ready), 32'd1);
        chk("rst_flush_busy", 32'(flush_busy), 32'd0);
        chk("rst_acc0", 32'(acc0_cnt), 32'd0);

        // Round-robin with both producers always valid
        do_reset();
        for (int k = 0; k < 8; k++) begin
            q.push_back(8'h10 + 8'(k));
            q.push_back(8'h20 + 8'(k));
        end
        req0_data = 8'h10; req1_data = 8'h20;
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        g = 0;
        while (n0 + n1 < 16 && g < 100) begin step(); g++; end
        chk("rr_writes", 32'(n0 + n1), 32'd16);
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain(50);
        chk("rr_acc0", 32'(acc0_cnt), 32'd8);
        chk("rr_acc1", 32'(acc1_cnt), 32'd8);
        chk("rr_level", 32'(level), 32'd0);

        // Full back-pressure: 16 in the FIFO plus one held on the output
        do_reset();
        for (int k = 0; k < 17; k++) q.push_back(8'h30 + 8'(k));
        req0_data = 8'h30; req0_valid = 1'b1;
        repeat (20) step();
        chk("bp_accepted", 32'(n0), 32'd17);
        chk("bp_level", 32'(level), 32'd17);
        #1;
        chk("bp_req0_ready", 32'(req0_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        req0_valid = 1'b0; out_ready = 1'b1;
        drain(40);
        chk("bp_level_after", 32'(level), 32'd0);

        // Streaming: 5 preloaded words leave on 5 consecutive cycles
        do_reset();
        for (int k = 0; k < 5; k++) q.push_back(8'h50 + 8'(k));
        req1_data = 8'h50; req1_valid = 1'b1;
        repeat (5) step();
        chk("st_level", 32'(level), 32'd5);
        req1_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("st_out_valid", 32'(out_valid), 32'd1);
            step();
        end
        #1;
        chk("st_out_valid_end", 32'(out_valid), 32'd0);
        chk("st_level_end", 32'(level), 32'd0);
        chk("st_sb_empty", 32'(q.size()), 32'd0);

        // Output stall: out_ready alternates, held word must not move
        do_reset();
        for (int k = 0; k < 4; k++) q.push_back(8'h60 + 8'(k));
        req0_data = 8'h60; req0_valid = 1'b1;
        repeat (4) step();
        req0_valid = 1'b0;
        prev_stall = 1'b0; prev_data = '0;
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 2 == 1);
            #1;
            if (prev_stall) chk("stall_hold", 32'(out_data), 32'(prev_data));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step();
        end
        chk("stall_sb_empty", 32'(q.size()), 32'd0);
        chk("stall_level", 32'(level), 32'd0);

        // Flush with a held output word and 9 words in the FIFO
        do_reset();
        req0_data = 8'h70; req0_valid = 1'b1;
        repeat (10) step();
        req0_valid = 1'b0;
        chk("fl_pre_level", 32'(level), 32'd10);
        chk("fl_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1; req1_valid = 1'b1; req1_data = 8'hAA;
        #1;
        chk("fl_entry_req1_ready", 32'(req1_ready), 32'd1);
        step();
        flush = 1'b0; req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 8'hBB;
        chk("fl_entry_level", 32'(level), 32'd10);
        nb = 0;
        while (flush_busy && nb < 30) begin
            #1;
            chk("fl_req0_blocked", 32'(req0_ready), 32'd0);
            chk("fl_out_valid", 32'(out_valid), 32'd0);
            step();
            nb++;
        end
        chk("fl_busy_cycles", 32'(nb), 32'd11);
        chk("fl_level_end", 32'(level), 32'd0);
        chk("fl_out_valid_end", 32'(out_valid), 32'd0);
        q.push_back(8'hBB);
        out_ready = 1'b1;
        step();
        req0_valid = 1'b0;
        drain(10);

        // Reset with an output word held
        do_reset();
        req1_data = 8'hC0; req1_valid = 1'b1;
        repeat (3) step();
        req1_valid = 1'b0;
        chk("mr_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_level", 32'(level), 32'd0);
        chk("mr_acc1", 32'(acc1_cnt), 32'd0);
        chk("mr_fifo_empty", 32'(fifo_empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
